// File: rtl/uart_apb_regs.sv
// UART APB register block: control/status registers plus TX and RX byte
// FIFOs exchanged with the serial core over valid/ready handshakes.

// Circular byte FIFO with power-of-two depth and wrapping pointers.
module uart_apb_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       push_req,
  input  logic [7:0] wdata,
  input  logic       pop_req,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic       ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A pop on an empty FIFO is a no-op; a pop on a full FIFO frees the slot
  // the same-cycle push lands in, so only an un-popped full FIFO overflows.
  assign pop  = pop_req & ~empty;
  assign push = push_req & (~full | pop);
  assign ovf  = push_req & full & ~pop;

  // Empty FIFO presents zero so the head never exposes stale storage.
  assign head = empty ? 8'h00 : mem[rptr];

  // NOTE: storage array has no reset; validity is tracked by count/pointers.
  always_ff @(posedge pclk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy count.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// APB slave register block.
module uart_apb_regs #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BAUD_RST   = 16'd27
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  output logic [31:0] prdata,
  output logic        uart_int,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        tx_en,
  output logic        rx_en,
  output logic [15:0] baud_div
);

  localparam logic [5:0] REG_TXDATA = 6'h00;
  localparam logic [5:0] REG_RXDATA = 6'h01;
  localparam logic [5:0] REG_STATUS = 6'h02;
  localparam logic [5:0] REG_CTRL   = 6'h03;
  localparam logic [5:0] REG_BAUD   = 6'h04;

  logic [5:0]  reg_sel;
  logic        setup_rd;
  logic        acc_wr;
  logic        acc_rd;

  logic [3:0]  ctrl;
  logic        rx_int_en;
  logic        tx_int_en;
  logic        rx_ovf;
  logic        tx_ovf;

  logic        tx_push_req;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_ovf_set;
  logic [7:0]  tx_head;

  logic        rx_push_req;
  logic        rx_pop_req;
  logic        rx_full;
  logic        rx_empty;
  logic        rx_ovf_set;
  logic [7:0]  rx_head;

  logic        tx_ovf_clr;
  logic        rx_ovf_clr;
  logic [31:0] rd_mux;
  logic        int_cond;
  logic        unused_bits;

  assign reg_sel  = paddr[7:2];
  assign setup_rd = psel & ~penable & ~pwrite;
  assign acc_wr   = psel & penable & pwrite;
  assign acc_rd   = psel & penable & ~pwrite;

  assign unused_bits = ^{paddr[31:8], paddr[1:0], pwdata[31:16]};

  assign tx_en     = ctrl[0];
  assign rx_en     = ctrl[1];
  assign rx_int_en = ctrl[2];
  assign tx_int_en = ctrl[3];

  // TX path: bus pushes, serial core pops on handshake.
  assign tx_push_req = acc_wr & (reg_sel == REG_TXDATA);
  assign tx_valid    = tx_en & ~tx_empty;
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_data     = tx_head;

  uart_apb_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .pclk     (pclk),
    .presetn  (presetn),
    .push_req (tx_push_req),
    .wdata    (pwdata[7:0]),
    .pop_req  (tx_pop),
    .head     (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .ovf      (tx_ovf_set)
  );

  // RX path: serial core pushes, a bus read of RXDATA pops.
  assign rx_push_req = rx_valid & rx_en;
  assign rx_pop_req  = acc_rd & (reg_sel == REG_RXDATA);

  uart_apb_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .pclk     (pclk),
    .presetn  (presetn),
    .push_req (rx_push_req),
    .wdata    (rx_data),
    .pop_req  (rx_pop_req),
    .head     (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .ovf      (rx_ovf_set)
  );

  assign tx_ovf_clr = acc_wr & (reg_sel == REG_STATUS) & pwdata[5];
  assign rx_ovf_clr = acc_wr & (reg_sel == REG_STATUS) & pwdata[4];

  // Read data selection from current state.
  // NOTE: every combinational output gets a default first so no latch forms.
  always_comb begin
    rd_mux = 32'h0;
    case (reg_sel)
      REG_RXDATA: rd_mux = {24'h0, rx_head};
      REG_STATUS: rd_mux = {26'h0, tx_ovf, rx_ovf, rx_empty, rx_full,
                            tx_empty, tx_full};
      REG_CTRL:   rd_mux = {28'h0, ctrl};
      REG_BAUD:   rd_mux = {16'h0, baud_div};
      default:    rd_mux = 32'h0;
    endcase
  end

  assign int_cond = (rx_int_en & ~rx_empty) | (tx_int_en & tx_empty)
                  | rx_ovf | tx_ovf;

  // Configuration registers, sticky overflow flags, read data and interrupt.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl     <= 4'h0;
      baud_div <= BAUD_RST;
      tx_ovf   <= 1'b0;
      rx_ovf   <= 1'b0;
      prdata   <= 32'h0;
      uart_int <= 1'b0;
    end else begin
      if (acc_wr && reg_sel == REG_CTRL) ctrl     <= pwdata[3:0];
      if (acc_wr && reg_sel == REG_BAUD) baud_div <= pwdata[15:0];
      // A set arriving with a clear wins, so no overflow event is lost.
      tx_ovf   <= tx_ovf_set | (tx_ovf & ~tx_ovf_clr);
      rx_ovf   <= rx_ovf_set | (rx_ovf & ~rx_ovf_clr);
      if (setup_rd) prdata <= rd_mux;
      uart_int <= int_cond;
    end
  end

endmodule

// File: tb/tb_uart_apb_regs.sv
// Directed self-checking bench for uart_apb_regs (FIFO_DEPTH = 16).
module tb_uart_apb_regs;

  localparam int DEPTH = 16;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] prdata;
  logic        uart_int;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_en;
  logic        rx_en;
  logic [15:0] baud_div;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [31:0] rd;

  uart_apb_regs #(.FIFO_DEPTH(DEPTH), .BAUD_RST(16'd27)) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .prdata   (prdata),
    .uart_int (uart_int),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_en    (tx_en),
    .rx_en    (rx_en),
    .baud_div (baud_div)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = {24'h0, addr}; pwdata = data;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {24'h0, addr};
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    data = prdata;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    presetn = 1'b0; paddr = '0; pwdata = '0; psel = 1'b0; penable = 1'b0;
    pwrite = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(negedge pclk);

    // Reset state
    check("rst_prdata", prdata, 32'h0);
    check("rst_int", {31'h0, uart_int}, 32'h0);
    check("rst_txvalid", {31'h0, tx_valid}, 32'h0);
    check("rst_txdata", {24'h0, tx_data}, 32'h0);
    check("rst_baud", {16'h0, baud_div}, 32'h1B);
    presetn = 1'b1;
    apb_read(8'h08, rd); check("rst_status", rd, 32'h0000000A);
    apb_read(8'h10, rd); check("rst_baud_rd", rd, 32'h0000001B);
    check("rst_int2", {31'h0, uart_int}, 32'h0);

    // TX handshake
    apb_write(8'h0C, 32'h1);
    check("tx_en", {31'h0, tx_en}, 32'h1);
    apb_write(8'h00, 32'h55);
    apb_write(8'h00, 32'hAA);
    check("tx_head0", {24'h0, tx_data}, 32'h55);
    check("tx_valid0", {31'h0, tx_valid}, 32'h1);
    apb_read(8'h08, rd); check("tx_status_busy", rd, 32'h00000008);
    tx_ready = 1'b1;
    @(negedge pclk);
    check("tx_head1", {24'h0, tx_data}, 32'hAA);
    check("tx_valid1", {31'h0, tx_valid}, 32'h1);
    @(negedge pclk);
    check("tx_valid_done", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    apb_read(8'h08, rd); check("tx_status_empty", rd, 32'h0000000A);

    // RX interrupt and read
    apb_write(8'h0C, 32'h6);
    rx_data = 8'h3C; rx_valid = 1'b1;
    @(negedge pclk);
    rx_valid = 1'b0;
    check("rx_int_early", {31'h0, uart_int}, 32'h0);
    @(negedge pclk);
    check("rx_int_set", {31'h0, uart_int}, 32'h1);
    apb_read(8'h04, rd); check("rx_data", rd, 32'h0000003C);
    @(negedge pclk);
    check("rx_int_clr", {31'h0, uart_int}, 32'h0);
    apb_read(8'h08, rd); check("rx_status_empty", rd, 32'h0000000A);

    // TX overflow with transmit disabled
    for (int i = 0; i <= DEPTH; i++) apb_write(8'h00, 32'(i + 1));
    apb_read(8'h08, rd); check("txovf_status", rd, 32'h00000029);
    check("txovf_int", {31'h0, uart_int}, 32'h1);
    check("txovf_novalid", {31'h0, tx_valid}, 32'h0);
    apb_write(8'h08, 32'h20);
    apb_read(8'h08, rd); check("txovf_w1c", rd, 32'h00000009);
    check("txovf_int_clr", {31'h0, uart_int}, 32'h0);
    apb_write(8'h0C, 32'h1);
    tx_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("tx_drain%0d", i), {24'h0, tx_data}, 32'(i));
      @(negedge pclk);
    end
    check("tx_drained", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // RX full with simultaneous push and pop
    apb_write(8'h0C, 32'h2);
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 8'(8'h80 + i); rx_valid = 1'b1;
      @(negedge pclk);
    end
    rx_valid = 1'b0;
    apb_read(8'h08, rd); check("rx_full", rd, 32'h00000006);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04;
    @(negedge pclk);
    penable = 1'b1; rx_data = 8'hEE; rx_valid = 1'b1;
    @(negedge pclk);
    check("rx_simul_data", prdata, 32'h00000080);
    psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
    apb_read(8'h08, rd); check("rx_simul_noovf", rd, 32'h00000006);
    for (int i = 1; i < DEPTH; i++) begin
      apb_read(8'h04, rd); check($sformatf("rx_drain%0d", i), rd, 32'(8'h80 + i));
    end
    apb_read(8'h04, rd); check("rx_last_new", rd, 32'h000000EE);
    apb_read(8'h08, rd); check("rx_empty_again", rd, 32'h0000000A);

    // RX overflow, then set-versus-clear precedence
    for (int i = 0; i <= DEPTH; i++) begin
      rx_data = 8'(i); rx_valid = 1'b1;
      @(negedge pclk);
    end
    rx_valid = 1'b0;
    apb_read(8'h08, rd); check("rxovf_status", rd, 32'h00000016);
    check("rxovf_int", {31'h0, uart_int}, 32'h1);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h10;
    @(negedge pclk);
    penable = 1'b1; rx_data = 8'h77; rx_valid = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_valid = 1'b0;
    apb_read(8'h08, rd); check("rxovf_set_wins", rd, 32'h00000016);
    apb_write(8'h08, 32'h10);
    apb_read(8'h08, rd); check("rxovf_w1c", rd, 32'h00000006);

    // Register readback and unmapped offset
    apb_read(8'h0C, rd); check("ctrl_rd", rd, 32'h00000002);
    apb_write(8'h10, 32'hFFFF1234);
    apb_read(8'h10, rd); check("baud_rd", rd, 32'h00001234);
    check("baud_out", {16'h0, baud_div}, 32'h1234);
    apb_write(8'h14, 32'hFFFFFFFF);
    apb_read(8'h14, rd); check("unmapped_rd", rd, 32'h0);

    // Reset during the access phase of a BAUD_DIV write
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h100;
    @(negedge pclk);
    penable = 1'b1;
    #2 presetn = 1'b0;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("abort_baud", {16'h0, baud_div}, 32'h1B);
    check("abort_ctrl", {30'h0, rx_en, tx_en}, 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    apb_read(8'h08, rd); check("abort_status", rd, 32'h0000000A);
    rx_data = 8'h99; rx_valid = 1'b1;
    @(negedge pclk);
    rx_valid = 1'b0;
    apb_read(8'h08, rd); check("rx_disabled", rd, 32'h0000000A);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_apb_regs.md
Name: uart_apb_regs

Overview:
APB slave register block of the UART, one stage downstream of the APB bus interface. It decodes APB transfers on pclk into control/status registers, a TX FIFO and an RX FIFO. It exchanges bytes with the UART serial core by valid/ready handshakes and drives the level interrupt uart_int back onto the bus interface. Transfers are zero-wait-state; the bus has no pready or pslverr.

Parameters:
FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, 2 to 256.
BAUD_RST, 16'd27, reset value of BAUD_DIV.

Ports:
pclk  in  1  clock; all logic on its rising edge.
presetn  in  1  reset, asynchronous assert, active-low.
paddr  in  32  byte address; only [7:2] decoded.
pwdata  in  32  write data.
psel  in  1  slave select.
penable  in  1  access phase.
pwrite  in  1  1 = write, 0 = read.
prdata  out  32  read data, valid throughout the access phase.
uart_int  out  1  level interrupt, registered.
tx_data  out  8  byte at the head of the TX FIFO.
tx_valid  out  1  TX byte available (TX FIFO not empty and CTRL.tx_en).
tx_ready  in  1  core accepts tx_data when tx_valid and tx_ready are both high.
rx_data  in  8  received byte.
rx_valid  in  1  one-cycle strobe: push rx_data.
tx_en  out  1  CTRL bit 0.
rx_en  out  1  CTRL bit 1.
baud_div  out  16  BAUD_DIV register.

Behaviour:
- Reset (async, presetn low): prdata=0, uart_int=0, both FIFOs empty with pointers 0, CTRL=0, ovf flags=0, baud_div=BAUD_RST, tx_valid=0, tx_data=0.
- Setup phase = psel & !penable. Access phase = psel & penable.
- Reads: prdata is registered at the setup-phase edge from the current state and held through the access phase. Read side effects take effect at the access-phase edge.
- Writes commit at the access-phase edge.
- Register map (paddr[7:0]):
  - 0x00 TXDATA (W): push pwdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set. Reads 0.
  - 0x04 RXDATA (R): prdata={24'b0, head byte}; pop at the access edge. If the FIFO is empty, returns 0 and does not pop. Writes ignored.
  - 0x08 STATUS:
    - Read bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] rx_ovf, [5] tx_ovf. Other bits 0.
    - Write: 1 to bit 4 or bit 5 clears that flag (W1C).
  - 0x0C CTRL (RW): [0] tx_en, [1] rx_en, [2] rx_int_en, [3] tx_int_en. Upper bits read 0.
  - 0x10 BAUD_DIV (RW): bits [15:0].
  - All other offsets read 0; writes to them are ignored.
- TX side:
  - Core pops the FIFO when tx_valid & tx_ready; the next head is presented the following cycle.
  - When CTRL.tx_en=0: tx_valid=0 and the FIFO contents are retained.
- RX side:
  - rx_valid with rx_en=1 pushes rx_data.
  - If the RX FIFO is full, the byte is dropped and rx_ovf is set.
  - rx_valid with rx_en=0 is ignored.
- Simultaneous events:
  - Push and pop in the same cycle both occur, and the level is unchanged. On a full FIFO, a same-cycle pop makes room, so there is no overflow. On an empty FIFO, a same-cycle pop has no effect and the push succeeds.
  - A flag set and a W1C clear in the same cycle leave the flag set.
- Each FIFO is a circular buffer with log2(FIFO_DEPTH) pointers that wrap, plus a count of log2(FIFO_DEPTH)+1 bits; full means count==FIFO_DEPTH.
- uart_int is registered one cycle after its condition: (rx_int_en & !rx_empty) | (tx_int_en & tx_empty) | rx_ovf | tx_ovf.
- Reset asserted mid-transfer aborts the transfer. No partial write commits. State returns to reset values immediately.

Test Plan:
- Reset, then read 0x08 -> 0x0000000A; read 0x10 -> 0x0000001B; uart_int=0.
- Set CTRL=0x1, write TXDATA 0x55 then 0xAA with tx_ready=1 -> tx_data presents 0x55 then 0xAA on consecutive handshakes; STATUS bit1 returns to 1.
- Set CTRL=0x6, pulse rx_valid with 0x3C -> uart_int=1 two cycles after the strobe. Read 0x04 -> 0x3C, then uart_int=0 and STATUS bit3=1.
- With tx_en=0, do FIFO_DEPTH+1 TXDATA writes -> STATUS bit0=1 and bit5=1, uart_int=1. Write 0x20 to 0x08 -> bit5=0.
- Fill the RX FIFO, then pulse rx_valid in the same cycle as an RXDATA access -> no rx_ovf; level stays FIFO_DEPTH; the new byte is read last.
- Drop presetn during the access phase of a BAUD_DIV write of 0x100 -> baud_div=0x1B; FIFOs are empty after release.
